// File: rtl/systolic_scheduler.sv
// Operand-tile sequencer for an N x N systolic multiply array: skewed edge feeds, flush, serial drain.
// Optional cycle counter on perf_cycles is built only when SYSTOLIC_SCHED_PERF_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | operand buffers writable, waiting for start
// CLEAR | one cycle of arr_clear to zero all accumulators
// FEED  | K+N-1 cycles of diagonally skewed row/column operands
// FLUSH | N cycles of zero feeds while the last products settle
// DRAIN | serial read-back of N*N accumulators over valid/ready
module systolic_scheduler #(
   parameter int N = 4,
   parameter int K = 4,
   parameter int W = 8,
   localparam int IW  = $clog2((N > K) ? N : K),
   localparam int RIW = $clog2(N * N)
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [IW-1:0]    wr_row,
   input  logic [IW-1:0]    wr_col,
   input  logic [W-1:0]     wr_data,
   output logic             arr_clear,
   output logic [N*W-1:0]   arr_a,
   output logic [N*W-1:0]   arr_b,
   input  logic [N*N*W-1:0] arr_c,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic [RIW-1:0]   res_idx,
   output logic [15:0]      perf_cycles
);

   localparam int FEED_LAST = K + N - 2;
   localparam int NN        = N * N;
   localparam int CW        = $clog2(K + N);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [RIW-1:0]   res_idx_nxt;
   logic             res_valid_nxt, done_nxt, clear_nxt, busy_nxt, wr_ok;
   logic [N*W-1:0]   a_nxt, b_nxt;
   int               feed_t;

   logic [W-1:0]     a_buf [N][K];
   logic [W-1:0]     b_buf [K][N];

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      res_idx_nxt   = res_idx;
      res_valid_nxt = res_valid;
      done_nxt      = 1'b0;
      clear_nxt     = 1'b0;
      wr_ok         = 1'b0;
      feed_t        = -1;
      case (state)
         IDLE: begin
            wr_ok = wr_en;
            if (start) begin
               state_nxt = CLEAR;
               clear_nxt = 1'b1;
            end
         end
         CLEAR: begin
            state_nxt = FEED;
            cnt_nxt   = CW'(FEED_LAST);
            feed_t    = 0;
         end
         FEED: begin
            // cnt is the remaining FEED time; registered feeds are one step ahead
            feed_t = FEED_LAST - int'(cnt) + 1;
            if (cnt == '0) begin
               state_nxt = FLUSH;
               cnt_nxt   = CW'(N - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         FLUSH: begin
            if (cnt == '0) begin
               state_nxt     = DRAIN;
               res_valid_nxt = 1'b1;
               res_idx_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DRAIN: begin
            if (res_ready) begin
               if (res_idx == RIW'(NN - 1)) begin
                  state_nxt     = IDLE;
                  res_valid_nxt = 1'b0;
                  res_idx_nxt   = '0;
                  done_nxt      = 1'b1;
               end else begin
                  res_idx_nxt = res_idx + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Row i sees A[i][t-i], column j sees B[t-j][j]
   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            if (feed_t == i + k) a_nxt[i*W +: W] = a_buf[i][k];
            if (feed_t == i + k) b_nxt[i*W +: W] = b_buf[k][i];
         end
   end

   always_comb begin
      res_data = '0;
      for (int p = 0; p < NN; p++)
         if (res_idx == RIW'(p)) res_data = arr_c[p*W +: W];
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         arr_clear <= 1'b0;
         arr_a     <= '0;
         arr_b     <= '0;
         res_valid <= 1'b0;
         res_idx   <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         arr_clear <= clear_nxt;
         arr_a     <= a_nxt;
         arr_b     <= b_nxt;
         res_valid <= res_valid_nxt;
         res_idx   <= res_idx_nxt;
      end
   end

   // Out-of-range indices match no entry and are dropped
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
               a_buf[i][k] <= '0;
               b_buf[k][i] <= '0;
            end
      end else if (wr_ok) begin
         for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
               if (!wr_sel && wr_row == IW'(i) && wr_col == IW'(k)) a_buf[i][k] <= wr_data;
               if (wr_sel && wr_row == IW'(k) && wr_col == IW'(i)) b_buf[k][i] <= wr_data;
            end
      end
   end

`ifdef SYSTOLIC_SCHED_PERF_EN
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         perf_cycles <= '0;
      else if (state == IDLE && start)
         perf_cycles <= '0;
      else if (state != IDLE && perf_cycles != 16'hFFFF)
         perf_cycles <= perf_cycles + 1'b1;
   end
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: doc/systolic_scheduler.md
# systolic_scheduler

Sequencer for an N×N systolic multiply array built from the team's processing elements. It holds one A (N×K) and one B (K×N) operand tile, clears the array accumulators, and drives the row/column edges with the diagonally skewed operand streams. After the last partial product has settled, it reads back the N×N accumulator outputs serially over a valid/ready result port.

## Interface
- N, 4, array dimension (rows = columns); N ≥ 2
- K, 4, inner dimension (beats per dot product); K ≥ 1
- W, 8, operand/accumulator width, matching the element datapath
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs return to reset values while low
- start  in  1  job request, sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last result is accepted
- wr_en  in  1  operand buffer write strobe, honoured only in IDLE
- wr_sel  in  1  0 = A buffer (wr_row = i, wr_col = k); 1 = B buffer (wr_row = k, wr_col = j)
- wr_row  in  clog2(max(N,K))  first index
- wr_col  in  clog2(max(N,K))  second index
- wr_data  in  W  operand value
- arr_clear  out  1  active-high synchronous accumulator clear to all elements
- arr_a  out  N*W  row-edge feeds; slice i drives row i
- arr_b  out  N*W  column-edge feeds; slice j drives column j
- arr_c  in  N*N*W  accumulator outputs; slice i*N+j = element (i,j)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts when high with res_valid
- res_data  out  W  element (i,j) accumulator value
- res_idx  out  clog2(N*N)  i*N+j, row-major
- perf_cycles  out  16  see Configuration

## Operation
- States: IDLE → CLEAR → FEED → FLUSH → DRAIN → IDLE.
- IDLE: start=1 → CLEAR. wr_en writes the selected buffer. Out-of-range indices are ignored.
- CLEAR: 1 cycle; arr_clear=1; arr_a/arr_b=0.
- FEED: K+N-1 cycles, t = 0..K+N-2. Slice i of arr_a = A[i][t-i] when 0 ≤ t-i < K, else 0. Slice j of arr_b = B[t-j][j] when 0 ≤ t-j < K, else 0.
- FLUSH: N cycles with arr_a/arr_b=0, so the final product reaching element (N-1,N-1) is registered.
- DRAIN: res_idx counts 0..N*N-1. res_data = arr_c slice res_idx, passed through unchanged; arithmetic wraps mod 2^W inside the elements. The index advances on res_valid & res_ready. Acceptance of index N*N-1 → IDLE with done=1 for that one cycle.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - wr_en while busy: ignored; buffers are locked during a job.
  - Operand buffers persist across jobs, so a start with no writes reruns the previous operands.
  - reset low in any state: immediate return to IDLE, outputs at reset values, buffers zeroed.

## Timing
- Reset values: busy=0, done=0, arr_clear=0, arr_a=0, arr_b=0, res_valid=0, res_data=0, res_idx=0, perf_cycles=0.
- All outputs are registered. res_data is the exception: it is a combinational mux of arr_c selected by registered res_idx.
- Cycle numbering: start sampled at edge 0. CLEAR is cycle 1. FEED is cycles 2..K+N. FLUSH is cycles K+N+1..K+2N. The first res_valid is in cycle K+2N+1 (13 for defaults).
- res_valid stays high throughout DRAIN. With res_ready held high, one result per cycle; the last is accepted in cycle K+2N+N*N.
- res_ready low stalls DRAIN indefinitely; res_idx and res_data stay stable.
- busy falls on the edge after the last acceptance, coincident with done rising. A new start is accepted one cycle later.

## Configuration
- SYSTOLIC_SCHED_PERF_EN defined:
  - perf_cycles counts cycles spent outside IDLE for the current job.
  - It saturates at 16'hFFFF, clears on start acceptance, and holds its value in IDLE.
  - Defaults, no stall: reads 28 after done.
- Not defined: perf_cycles is tied to 0 and the counter logic is absent.

## Test plan
- Identity: A=I, B[k][j]=k*4+j+1, start, res_ready=1 → res_data 1..16 in idx order 0..15, first valid in cycle 13, done in the cycle after the last acceptance.
- Wrap: all A=16, all B=16 → every result 1024 mod 256 = 0. Then all A=3, all B=5 → every result 60.
- Backpressure: res_ready toggled 1,0,0,1,… → no index skipped or repeated; res_data is stable while stalled; done appears only after idx 15 is accepted.
- Protocol abuse: start and wr_en (A[0][0]=99) asserted during FEED → no second job, and a rerun shows A[0][0] unchanged.
- Async reset: reset low mid-FEED for 1 cycle → outputs zero within the same cycle, state IDLE, buffers zero; the next job yields all-0 results.
- SYSTOLIC_SCHED_PERF_EN built: identity job with no stall → perf_cycles=28. With 5 stall cycles → 33.
